// File: rtl/led_debug_monitor.sv
// Registered LED debug display for the RV32I pipeline probe bus.
// Four views: live probe slice, frozen snapshot slice, auto-scrolling
// slice and cycle/retire performance counters.
module led_debug_monitor #(
  parameter int NUM_CH     = 8,
  parameter int DATA_W     = 32,
  parameter int LED_W      = 16,
  parameter int SCROLL_DIV = 1000,
  parameter int SEL_W      = $clog2(NUM_CH*DATA_W/LED_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] probe_in,
  input  logic                     probe_valid,
  input  logic                     freeze_req,
  input  logic [1:0]               mode,
  input  logic [SEL_W-1:0]         ledSel,
  output logic [LED_W-1:0]         Led_out,
  output logic                     frozen,
  output logic [31:0]              cycle_cnt,
  output logic [31:0]              retire_cnt
);

  localparam int NSL = NUM_CH*DATA_W/LED_W;   // display slices across all probes
  localparam int IW  = $clog2(NSL);           // slice index width
  localparam int R   = 32/LED_W;              // slices per 32-bit counter
  localparam int CB  = $clog2(2*R);           // counter-slice index width
  localparam int PW  = $clog2(SCROLL_DIV);    // prescaler width

  typedef enum logic [1:0] {
    M_LIVE   = 2'b00,
    M_SNAP   = 2'b01,
    M_SCROLL = 2'b10,
    M_CNT    = 2'b11
  } mode_t;

  logic [NUM_CH*DATA_W-1:0]    snapshot;
  logic [IW-1:0]               scroll_idx;
  logic [PW-1:0]               prescaler;
  logic [1:0]                  prev_mode;

  // Slice views: packed reinterpretation, slice k = bits [k*LED_W +: LED_W]
  logic [NSL-1:0][LED_W-1:0]   live_sl;
  logic [NSL-1:0][LED_W-1:0]   snap_sl;
  logic [2*R-1:0][LED_W-1:0]   cnt_sl;

  assign live_sl = probe_in;
  assign snap_sl = snapshot;
  assign cnt_sl  = {retire_cnt, cycle_cnt};

  logic                        sel_ok;
  logic [IW-1:0]               sel_idx;
  logic [CB-1:0]               cnt_idx;
  logic                        scroll_entry;
  logic [IW-1:0]               idx_nxt;
  logic [PW-1:0]               pres_nxt;
  logic [LED_W-1:0]            led_nxt;

  assign sel_ok       = {1'b0, ledSel} < (SEL_W+1)'(NSL);
  assign sel_idx      = IW'(ledSel);
  assign cnt_idx      = CB'(ledSel);
  assign scroll_entry = (mode == M_SCROLL) && (prev_mode != M_SCROLL);

  // Scroll position/prescaler for this clock; held outside auto-scroll
  always_comb begin
    idx_nxt  = scroll_idx;
    pres_nxt = prescaler;
    if (mode == M_SCROLL) begin
      if (scroll_entry) begin
        // an unmappable ledSel on entry starts the scroll at slice 0
        idx_nxt  = sel_ok ? sel_idx : '0;
        pres_nxt = '0;
      end else if (prescaler == PW'(SCROLL_DIV-1)) begin
        pres_nxt = '0;
        idx_nxt  = (scroll_idx == IW'(NSL-1)) ? '0 : scroll_idx + 1'b1;
      end else begin
        pres_nxt = prescaler + 1'b1;
      end
    end
  end

  // Display source select; scroll view uses the updated index so a step
  // shows up on the same edge the index advances
  always_comb begin
    led_nxt = '0;
    case (mode_t'(mode))
      M_LIVE:   led_nxt = sel_ok ? live_sl[sel_idx] : '0;
      M_SNAP:   led_nxt = !sel_ok ? '0 : (frozen ? snap_sl[sel_idx] : live_sl[sel_idx]);
      M_SCROLL: led_nxt = frozen ? snap_sl[idx_nxt] : live_sl[idx_nxt];
      M_CNT:    led_nxt = cnt_sl[cnt_idx];
      default:  led_nxt = '0;
    endcase
  end

  // Output register: no combinational path from inputs to the LEDs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) Led_out <= '0;
    else     Led_out <= led_nxt;
  end

  // Freeze toggle and snapshot capture, independent of display mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frozen   <= 1'b0;
      snapshot <= '0;
    end else if (freeze_req) begin
      if (!frozen) begin
        snapshot <= probe_in;
        frozen   <= 1'b1;
      end else begin
        frozen   <= 1'b0;
      end
    end
  end

  // Auto-scroll state and mode history for entry detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scroll_idx <= '0;
      prescaler  <= '0;
      prev_mode  <= M_LIVE;
    end else begin
      scroll_idx <= idx_nxt;
      prescaler  <= pres_nxt;
      prev_mode  <= mode;
    end
  end

  // Performance counters run in every mode, wrapping at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      cycle_cnt  <= cycle_cnt + 32'd1;
      if (probe_valid) retire_cnt <= retire_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_led_debug_monitor.sv
// Bench for led_debug_monitor: directed scenarios plus random stimulus,
// all outputs compared every cycle against a behavioural model.
module tb_led_debug_monitor;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int LED_W  = 16;
  localparam int SD     = 4;
  localparam int SEL_W  = 4;
  localparam int NSL    = 8;

  localparam logic [127:0] P = {32'hDDDD4444, 32'hCCCC3333, 32'hBBBB2222, 32'hAAAA1111};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] probe_in = '0;
  logic         probe_valid = 1'b0;
  logic         freeze_req = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [3:0]   ledSel = '0;
  logic [15:0]  Led_out;
  logic         frozen;
  logic [31:0]  cycle_cnt, retire_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  led_debug_monitor #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .LED_W(LED_W),
    .SCROLL_DIV(SD), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst(rst), .probe_in(probe_in), .probe_valid(probe_valid),
    .freeze_req(freeze_req), .mode(mode), .ledSel(ledSel),
    .Led_out(Led_out), .frozen(frozen),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // reference state
  logic [127:0] m_snap;
  logic         m_frozen;
  logic [31:0]  m_cyc, m_ret;
  int           m_idx, m_pres;
  logic [1:0]   m_prev;
  logic [15:0]  m_led;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] slice_of(input logic [127:0] v, input int k);
    logic [127:0] s;
    s = v >> (16*k);
    return s[15:0];
  endfunction

  task automatic model_reset();
    m_snap = '0; m_frozen = 1'b0; m_cyc = '0; m_ret = '0;
    m_idx = 0; m_pres = 0; m_prev = 2'b00; m_led = '0;
  endtask

  task automatic model_step();
    logic [127:0] src;
    logic [31:0]  c;
    int           sel;
    sel = int'(ledSel);
    src = m_frozen ? m_snap : probe_in;
    if (mode == 2'b10) begin
      if (m_prev != 2'b10) begin m_idx = sel; m_pres = 0; end
      else if (m_pres == SD-1) begin m_pres = 0; m_idx = (m_idx + 1) % NSL; end
      else m_pres++;
    end
    case (mode)
      2'b00: m_led = (sel < NSL) ? slice_of(probe_in, sel) : 16'h0;
      2'b01: m_led = (sel < NSL) ? slice_of(src, sel) : 16'h0;
      2'b10: m_led = slice_of(src, m_idx);
      default: begin
        c = ((sel / 2) % 2 == 1) ? m_ret : m_cyc;
        m_led = (sel % 2 == 1) ? c[31:16] : c[15:0];
      end
    endcase
    m_cyc = m_cyc + 1;
    if (probe_valid) m_ret = m_ret + 1;
    if (freeze_req) begin
      if (!m_frozen) begin m_snap = probe_in; m_frozen = 1'b1; end
      else m_frozen = 1'b0;
    end
    m_prev = mode;
  endtask

  // one clock: advance model at the edge, compare on the falling edge
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    chk("led", {16'h0, Led_out}, {16'h0, m_led});
    chk("frozen", {31'h0, frozen}, {31'h0, m_frozen});
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("retire_cnt", retire_cnt, m_ret);
  endtask

  task automatic pulse_freeze();
    freeze_req = 1'b1;
    tick();
    freeze_req = 1'b0;
  endtask

  initial begin
    model_reset();
    // reset held two cycles
    tick(); tick();
    chk("rst_led", {16'h0, Led_out}, 32'h0);
    chk("rst_cyc", cycle_cnt, 32'h0);
    rst = 1'b0;

    // counters: 10 clocks, 3 retires
    for (int i = 0; i < 10; i++) begin
      probe_valid = (i < 3);
      tick();
    end
    probe_valid = 1'b0;
    chk("cyc10", cycle_cnt, 32'd10);
    chk("ret3", retire_cnt, 32'd3);

    // live selection, including out-of-range
    probe_in = P; mode = 2'b00; ledSel = 4'd3;
    tick();
    chk("live_sel3", {16'h0, Led_out}, 32'hBBBB);
    ledSel = 4'd8;
    tick();
    chk("live_sel8", {16'h0, Led_out}, 32'h0);

    // snapshot freeze / unfreeze
    mode = 2'b01; ledSel = 4'd0;
    pulse_freeze();
    probe_in = {32{4'h5}};
    tick();
    chk("snap_frozen", {31'h0, frozen}, 32'h1);
    chk("snap_led", {16'h0, Led_out}, 32'h1111);
    pulse_freeze();
    tick();
    chk("unfrozen", {31'h0, frozen}, 32'h0);
    chk("unfrozen_led", {16'h0, Led_out}, 32'h5555);

    // auto-scroll entry at slice 6, step after 4 cycles, wrap after 8
    probe_in = P; mode = 2'b00;
    tick();
    mode = 2'b10; ledSel = 4'd6;
    tick();
    chk("scroll_entry", {16'h0, Led_out}, 32'h4444);
    ledSel = 4'd1;
    tick(); tick(); tick();
    chk("scroll_hold", {16'h0, Led_out}, 32'h4444);
    tick();
    chk("scroll_step", {16'h0, Led_out}, 32'hDDDD);
    for (int i = 0; i < 4; i++) tick();
    chk("scroll_wrap", {16'h0, Led_out}, 32'h1111);

    // async reset mid-scroll while frozen
    pulse_freeze();
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("async_led", {16'h0, Led_out}, 32'h0);
    chk("async_frozen", {31'h0, frozen}, 32'h0);
    chk("async_cyc", cycle_cnt, 32'h0);
    model_reset();
    tick();
    ledSel = 4'd2;
    rst = 1'b0;
    tick();
    chk("post_rst_entry", {16'h0, Led_out}, 32'h2222);

    // counter display after a long run
    rst = 1'b1; tick(); rst = 1'b0;
    mode = 2'b00; ledSel = 4'd0;
    for (int i = 0; i < 65540; i++) tick();
    mode = 2'b11; ledSel = 4'd1;
    tick();
    chk("cnt_hi", {16'h0, Led_out}, 32'h0001);
    ledSel = 4'd0;
    tick();
    chk("cnt_lo", {16'h0, Led_out}, 32'h0005);
    ledSel = 4'd3;
    tick();
    chk("ret_hi", {16'h0, Led_out}, 32'h0000);

    // randomized traffic, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 10 == 0) mode = 2'($urandom);
      ledSel = (mode == 2'b10) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 9));
      if ($urandom % 2 == 0) probe_in = {$urandom, $urandom, $urandom, $urandom};
      probe_valid = 1'($urandom);
      freeze_req  = !freeze_req && ($urandom % 8 == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
